// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: opcode and FSM state
// encodings used by the top module and testbench.
package mc_datapath_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_BR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam int OP_W = 2;

endpackage

// File: rtl/mc_datapath_if.sv
// Memory-side bus of the multi-cycle datapath.
//   imem_*: instruction fetch handshake (req out, valid/data in)
//   dmem_*: data load/store handshake (req/we/addr/wdata out, ready/rdata in)
// master = datapath side, slave = memory side.
interface mc_datapath_if #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int PC_W   = 8
);
  localparam int INSTR_W = 2 + 3 * RA_W;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;

  logic               dmem_req;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ready;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_data,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_data,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mc_datapath_regfile.sv
// Register file: 2**RA_W words of DATA_W bits.
//   clk, rst       : clock, async active-high clear of every register
//   ra1/rd1,ra2/rd2: two asynchronous read ports
//   we/wa/wd       : one synchronous write port
module mc_datapath_regfile #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);
  localparam int NREGS = 2 ** RA_W;

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle CPU datapath, 4-op ISA (ADD/LW/SW/BR), instruction word
// {op[1:0], rs, rt, rd_imm}. Instruction and data memories sit behind
// req/ready handshakes on the bus interface and may insert wait states.
//   clk, rst  : clock, async active-high reset
//   run       : 0 holds in FETCH without requesting
//   bus       : imem/dmem handshakes (master side)
//   pc        : current program counter
//   wb_data   : last value written to the register file (held between writes)
//   wb_valid  : one-cycle pulse, high during the write-back cycle
//   state_dbg : current FSM state
//
// state    | meaning
// FETCH(0) | request imem[pc] while run; latch IR on valid
// EXEC(1)  | read rs/rt, compute ALUOUT; BR updates pc here
// MEM(2)   | hold dmem request until ready; LW captures data, SW retires
// WB(3)    | write rd (ADD) / rt (LW), advance pc
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  mc_datapath_if.master     bus,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic [1:0]        state_dbg
);
  localparam int INSTR_W = 2 + 3 * RA_W;

  state_e             state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  aluout;
  logic [DATA_W-1:0]  st_data;

  op_e               op;
  logic [RA_W-1:0]   rs_a;
  logic [RA_W-1:0]   rt_a;
  logic [RA_W-1:0]   imm;
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_p;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [RA_W-1:0]   wr_addr;

  assign op    = op_e'(ir[INSTR_W-1 -: OP_W]);
  assign rs_a  = ir[3*RA_W-1 -: RA_W];
  assign rt_a  = ir[2*RA_W-1 -: RA_W];
  assign imm   = ir[RA_W-1:0];
  assign imm_d = {{(DATA_W-RA_W){imm[RA_W-1]}}, imm};
  assign imm_p = {{(PC_W-RA_W){imm[RA_W-1]}}, imm};

  // ADD targets the rd field, LW targets rt.
  assign wr_addr = (op == OP_ADD) ? imm : rt_a;

  // Write data is wb_data: it is loaded on entry to WB so wb_data and
  // wb_valid present the written value together during the WB cycle.
  mc_datapath_regfile #(
    .DATA_W(DATA_W),
    .RA_W  (RA_W)
  ) u_regfile (
    .clk(clk),
    .rst(rst),
    .ra1(rs_a),
    .rd1(rs_val),
    .ra2(rt_a),
    .rd2(rt_val),
    .we (state == ST_WB),
    .wa (wr_addr),
    .wd (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= '0;
      ir       <= '0;
      aluout   <= '0;
      st_data  <= '0;
      wb_data  <= '0;
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        ST_FETCH: begin
          if (run && bus.imem_valid) begin
            ir    <= bus.imem_data;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          unique case (op)
            OP_ADD: begin
              aluout   <= rs_val + rt_val;
              wb_data  <= rs_val + rt_val;
              wb_valid <= 1'b1;
              state    <= ST_WB;
            end
            OP_LW, OP_SW: begin
              aluout  <= rs_val + imm_d;
              st_data <= rt_val;
              state   <= ST_MEM;
            end
            OP_BR: begin
              pc    <= pc + PC_W'(1) + imm_p;
              state <= ST_FETCH;
            end
            default: state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (bus.dmem_ready) begin
            if (op == OP_LW) begin
              wb_data  <= bus.dmem_rdata;
              wb_valid <= 1'b1;
              state    <= ST_WB;
            end else begin
              pc    <= pc + PC_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_WB: begin
          pc    <= pc + PC_W'(1);
          state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // The fetch request follows run combinationally so a pause takes effect
  // in the same cycle; rst gating keeps it low while reset is asserted.
  assign bus.imem_req   = (state == ST_FETCH) && run && !rst;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == ST_MEM);
  assign bus.dmem_we    = (state == ST_MEM) && (op == OP_SW);
  assign bus.dmem_addr  = aluout;
  assign bus.dmem_wdata = st_data;
  assign state_dbg      = state;
endmodule
